// File: rtl/rr_arb2_stage_pkg.sv
// Shared definitions for the two-input round-robin arbiter stage:
// last-grant state encoding and default widths.
package arb_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CNT_WIDTH  = 16;

  // The last granted port is the only arbitration state.
  typedef enum logic {
    LAST_B = 1'b0,
    LAST_A = 1'b1
  } last_gnt_e;

endpackage

// File: rtl/rr_arb2_stage_if.sv
// Handshake bundle for rr_arb2_stage: two producer streams (A, B),
// the steering select and the registered output stream.
// master = producers/consumer side, slave = arbiter side.
interface rr_arb2_stage_if
  import arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic                  a_valid;
  logic [DATA_WIDTH-1:0] a_data;
  logic                  a_ready;
  logic                  b_valid;
  logic [DATA_WIDTH-1:0] b_data;
  logic                  b_ready;
  logic                  sel;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;

  modport master (
    output a_valid, a_data, b_valid, b_data, out_ready,
    input  a_ready, b_ready, sel, out_valid, out_data
  );

  modport slave (
    input  a_valid, a_data, b_valid, b_data, out_ready,
    output a_ready, b_ready, sel, out_valid, out_data
  );

endinterface

// File: rtl/rr_arb2_stage_mux2_1.sv
// Plain 2:1 datapath mux: sel=1 picks a, sel=0 picks b.
module mux2_1 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  // Select between the two payloads.
  always_comb begin
    y = sel ? a : b;
  end

endmodule

// File: rtl/rr_arb2_stage.sv
// rr_arb2_stage: two-input round-robin stream arbiter feeding a one-deep
// registered output slot. Under contention the port that did not win last
// time is granted; a lone requester is always granted. The slot may drain
// and refill in the same cycle, giving one word per cycle.
// Optional build macro ARB_GNT_CNT_EN adds saturating per-port grant
// counters (a_gnt_cnt / b_gnt_cnt ports).
module rr_arb2_stage
  import arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_arb2_stage_if.slave       bus
`ifdef ARB_GNT_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] a_gnt_cnt,
  output logic [CNT_WIDTH-1:0] b_gnt_cnt
`endif
);

  if (CNT_WIDTH < 1) begin : g_bad_cnt_width
    $error("rr_arb2_stage: CNT_WIDTH must be at least 1");
  end

  last_gnt_e             state_q;
  last_gnt_e             state_d;
  logic                  any_valid;
  logic                  gnt_a;
  logic                  gnt_b;
  logic                  space;
  logic                  load;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [DATA_WIDTH-1:0] mux_y;

  // Grant decision and handshake outputs; ready is suppressed during reset.
  always_comb begin
    any_valid   = bus.a_valid || bus.b_valid;
    gnt_a       = bus.a_valid && (!bus.b_valid || (state_q == LAST_B));
    gnt_b       = bus.b_valid && !gnt_a;
    space       = !out_valid_q || bus.out_ready;
    load        = space && any_valid && !rst;
    bus.a_ready = load && gnt_a;
    bus.b_ready = load && gnt_b;
    bus.sel     = any_valid ? gnt_a : (state_q == LAST_A);
  end

  // Next last-grant: only a completed load moves the round-robin pointer.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = gnt_a ? LAST_A : LAST_B;
    end
  end

  // Last-grant register; reset leaves B as last so A wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LAST_B;
    end else begin
      state_q <= state_d;
    end
  end

  mux2_1 #(
    .WIDTH (DATA_WIDTH)
  ) u_mux (
    .a   (bus.a_data),
    .b   (bus.b_data),
    .sel (gnt_a),
    .y   (mux_y)
  );

  // Output slot: load granted word, empty on drain without refill, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= mux_y;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Expose the registered slot.
  always_comb begin
    bus.out_valid = out_valid_q;
    bus.out_data  = out_data_q;
  end

`ifdef ARB_GNT_CNT_EN
  // Saturating grant counters, one step per accepted word.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_gnt_cnt <= '0;
      b_gnt_cnt <= '0;
    end else begin
      if (bus.a_ready && (a_gnt_cnt != '1)) begin
        a_gnt_cnt <= a_gnt_cnt + CNT_WIDTH'(1);
      end
      if (bus.b_ready && (b_gnt_cnt != '1)) begin
        b_gnt_cnt <= b_gnt_cnt + CNT_WIDTH'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_rr_arb2_stage.sv
// Self-checking bench for rr_arb2_stage. Directed scenarios use constant
// expectations; the random scenario compares against a word-level model of
// the arbitration rules. Define ARB_GNT_CNT_EN to exercise counters (CNT_WIDTH=4).
module tb_rr_arb2_stage;
  import arb_pkg::*;

  localparam int DW = 8;
`ifdef ARB_GNT_CNT_EN
  localparam int CW = 4;
`else
  localparam int CW = 16;
`endif
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  rr_arb2_stage_if #(.DATA_WIDTH(DW)) bus ();

`ifdef ARB_GNT_CNT_EN
  logic [CW-1:0] a_cnt;
  logic [CW-1:0] b_cnt;
  rr_arb2_stage #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .a_gnt_cnt(a_cnt), .b_gnt_cnt(b_cnt)
  );
`else
  rr_arb2_stage #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
`endif

  always #5 clk = ~clk;

  // Reference model: which port holds the "last winner" title, what word
  // sits in the output slot, and how many grants each port has received.
  bit          m_last_a;
  bit          m_ov;
  logic [DW-1:0] m_od;
  int          m_acnt;
  int          m_bcnt;
  int          exp_win;   // 0 none, 1 A, 2 B
  bit          exp_ar, exp_br, exp_sel;
  bit          last_ar, last_br;

  task automatic model_eval();
    if (bus.a_valid && bus.b_valid) exp_win = m_last_a ? 2 : 1;
    else if (bus.a_valid)           exp_win = 1;
    else if (bus.b_valid)           exp_win = 2;
    else                            exp_win = 0;
    exp_ar  = !rst && (!m_ov || bus.out_ready) && (exp_win == 1);
    exp_br  = !rst && (!m_ov || bus.out_ready) && (exp_win == 2);
    exp_sel = (exp_win == 0) ? m_last_a : (exp_win == 1);
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    if (rst) begin
      m_last_a = 0; m_ov = 0; m_od = '0; m_acnt = 0; m_bcnt = 0;
    end else if (exp_ar || exp_br) begin
      m_od = exp_ar ? bus.a_data : bus.b_data;
      m_ov = 1;
      m_last_a = exp_ar;
      if (exp_ar && m_acnt < CNT_MAX) m_acnt++;
      if (exp_br && m_bcnt < CNT_MAX) m_bcnt++;
    end else if (bus.out_ready) begin
      m_ov = 0;
    end
    last_ar = exp_ar;
    last_br = exp_br;
    #1;
  endtask

  task automatic idle_inputs();
    bus.a_valid = 0; bus.b_valid = 0; bus.a_data = '0; bus.b_data = '0; bus.out_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    bus.a_valid = 1; bus.b_valid = 1; bus.a_data = 8'h5A; bus.b_data = 8'hA5; bus.out_ready = 1;
    @(negedge clk);
    checks++;
    if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready_c1: a_ready=%b b_ready=%b required 0 0", bus.a_ready, bus.b_ready);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready_c2: a_ready=%b b_ready=%b required 0 0", bus.a_ready, bus.b_ready);
    end
    tick();
    rst = 0;
    idle_inputs();
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin
      errors++; $display("FAIL reset_slot: out_valid=%b out_data=%h required 0 00", bus.out_valid, bus.out_data);
    end
    checks++;
    if (bus.sel !== 1'b0) begin
      errors++; $display("FAIL reset_sel: sel=%b required 0", bus.sel);
    end
`ifdef ARB_GNT_CNT_EN
    checks++;
    if (a_cnt !== '0 || b_cnt !== '0) begin
      errors++; $display("FAIL reset_cnt: a_cnt=%0d b_cnt=%0d required 0 0", a_cnt, b_cnt);
    end
`endif
  endtask

  task automatic test_only_a();
    logic [7:0] w [3];
    w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33;
    do_reset();
    bus.out_ready = 1; bus.b_valid = 0; bus.b_data = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      bus.a_valid = 1; bus.a_data = w[i];
      @(negedge clk);
      checks++;
      if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0 || bus.sel !== 1'b1) begin
        errors++; $display("FAIL only_a_grant[%0d]: a_ready=%b b_ready=%b sel=%b required 1 0 1", i, bus.a_ready, bus.b_ready, bus.sel);
      end
      if (i > 0) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== w[i-1]) begin
          errors++; $display("FAIL only_a_out[%0d]: out_valid=%b out_data=%h required 1 %h", i, bus.out_valid, bus.out_data, w[i-1]);
        end
      end
      tick();
    end
    bus.a_valid = 0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h33 || bus.a_ready !== 1'b0) begin
      errors++; $display("FAIL only_a_last: out_valid=%b out_data=%h a_ready=%b required 1 33 0", bus.out_valid, bus.out_data, bus.a_ready);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.sel !== 1'b1) begin
      errors++; $display("FAIL only_a_drain: out_valid=%b sel=%b required 0 1", bus.out_valid, bus.sel);
    end
  endtask

  task automatic test_alternate();
    bit want_a;
    do_reset();
    bus.a_valid = 1; bus.b_valid = 1; bus.a_data = 8'hAA; bus.b_data = 8'hBB; bus.out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      want_a = (i % 2 == 0);
      @(negedge clk);
      checks++;
      if (bus.sel !== want_a || bus.a_ready !== want_a || bus.b_ready !== !want_a) begin
        errors++; $display("FAIL alternate_grant[%0d]: sel=%b a_ready=%b b_ready=%b required %b %b %b",
                           i, bus.sel, bus.a_ready, bus.b_ready, want_a, want_a, !want_a);
      end
      if (i > 0) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== (want_a ? 8'hBB : 8'hAA)) begin
          errors++; $display("FAIL alternate_out[%0d]: out_data=%h required %h", i, bus.out_data, want_a ? 8'hBB : 8'hAA);
        end
      end
      tick();
    end
  endtask

  // Continues from test_alternate: slot holds BB, B was last winner.
  task automatic test_stall();
    bus.out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hBB || bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin
        errors++; $display("FAIL stall[%0d]: out_valid=%b out_data=%h a_ready=%b b_ready=%b required 1 bb 0 0",
                           i, bus.out_valid, bus.out_data, bus.a_ready, bus.b_ready);
      end
      checks++;
      if (bus.sel !== 1'b1) begin
        errors++; $display("FAIL stall_sel[%0d]: sel=%b required 1", i, bus.sel);
      end
      tick();
    end
    bus.out_ready = 1;
    @(negedge clk);
    checks++;
    if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
      errors++; $display("FAIL stall_resume_a: a_ready=%b b_ready=%b required 1 0", bus.a_ready, bus.b_ready);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.out_data !== 8'hAA || bus.b_ready !== 1'b1 || bus.a_ready !== 1'b0) begin
      errors++; $display("FAIL stall_resume_b: out_data=%h a_ready=%b b_ready=%b required aa 0 1", bus.out_data, bus.a_ready, bus.b_ready);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [7:0] prev;
    do_reset();
    bus.out_ready = 1; bus.a_valid = 1;
    prev = '0;
    for (int i = 0; i < 8; i++) begin
      bus.a_data = 8'($urandom);
      @(negedge clk);
      checks++;
      if (bus.a_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_ready[%0d]: a_ready=%b required 1", i, bus.a_ready);
      end
      if (i > 0) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== prev) begin
          errors++; $display("FAIL b2b_out[%0d]: out_valid=%b out_data=%h required 1 %h", i, bus.out_valid, bus.out_data, prev);
        end
      end
      prev = bus.a_data;
      tick();
    end
    rst = 1;
    @(negedge clk);
    checks++;
    if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_rst_ready: a_ready=%b b_ready=%b required 0 0", bus.a_ready, bus.b_ready);
    end
    tick();
    rst = 0;
    bus.a_valid = 0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin
      errors++; $display("FAIL b2b_rst_slot: out_valid=%b out_data=%h required 0 00", bus.out_valid, bus.out_data);
    end
  endtask

`ifdef ARB_GNT_CNT_EN
  task automatic test_counters();
    int want;
    do_reset();
    bus.out_ready = 1; bus.a_valid = 1; bus.a_data = 8'h42;
    for (int i = 0; i < 20; i++) begin
      tick();
      want = (i + 1 > 15) ? 15 : i + 1;
      @(negedge clk);
      checks++;
      if (a_cnt !== CW'(want) || b_cnt !== '0) begin
        errors++; $display("FAIL cnt_sat[%0d]: a_cnt=%0d b_cnt=%0d required %0d 0", i, a_cnt, b_cnt, want);
      end
    end
    idle_inputs();
  endtask
`endif

  task automatic test_random();
    do_reset();
    last_ar = 0; last_br = 0;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 149) == 0);
      if (last_ar || !bus.a_valid) begin
        bus.a_valid = ($urandom_range(0, 99) < 60);
        bus.a_data  = 8'($urandom);
      end
      if (last_br || !bus.b_valid) begin
        bus.b_valid = ($urandom_range(0, 99) < 60);
        bus.b_data  = 8'($urandom);
      end
      bus.out_ready = ($urandom_range(0, 99) < 70);
      @(negedge clk);
      model_eval();
      checks++;
      if (bus.a_ready !== exp_ar || bus.b_ready !== exp_br || bus.sel !== exp_sel) begin
        errors++; $display("FAIL rand_grant[%0d]: a_ready=%b b_ready=%b sel=%b required %b %b %b",
                           n, bus.a_ready, bus.b_ready, bus.sel, exp_ar, exp_br, exp_sel);
      end
      checks++;
      if (bus.out_valid !== m_ov || bus.out_data !== m_od) begin
        errors++; $display("FAIL rand_slot[%0d]: out_valid=%b out_data=%h required %b %h",
                           n, bus.out_valid, bus.out_data, m_ov, m_od);
      end
`ifdef ARB_GNT_CNT_EN
      checks++;
      if (a_cnt !== CW'(m_acnt) || b_cnt !== CW'(m_bcnt)) begin
        errors++; $display("FAIL rand_cnt[%0d]: a_cnt=%0d b_cnt=%0d required %0d %0d", n, a_cnt, b_cnt, m_acnt, m_bcnt);
      end
`endif
      tick();
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    m_last_a = 0; m_ov = 0; m_od = '0; m_acnt = 0; m_bcnt = 0;
    last_ar = 0; last_br = 0;
    test_reset();
    test_only_a();
    test_alternate();
    test_stall();
    test_back_to_back();
`ifdef ARB_GNT_CNT_EN
    test_counters();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
